// File: rtl/locker_pkg.sv
// ---------------------------------------------------------------------------
// locker_pkg
// Shared types and width helpers for the multi-user locker.
//   state_t : top-level FSM states (IDLE / OPEN / LOCKOUT)
//   idx_w   : width of a user index for n users (never below 1)
//   cnt_w   : width of a saturating failure counter that reaches max_tries
//   tmr_w   : width of the shared countdown timer covering both windows
// ---------------------------------------------------------------------------
package locker_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPEN    = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int max_tries);
        return (max_tries > 0) ? $clog2(max_tries + 1) : 1;
    endfunction

    // The timer is loaded with (cycles - 1), so it must hold max(a, b) - 1.
    function automatic int tmr_w(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/lock_try_counter.sv
// ---------------------------------------------------------------------------
// lock_try_counter
// Per-user consecutive-failure counter, saturating at MAX_TRIES.
//   Clk   in  : system clock, rising edge
//   Reset in  : synchronous, active-high
//   inc   in  : count one failed attempt
//   clr   in  : clear to zero (wins over inc)
//   count out : current failure count, CW bits
// ---------------------------------------------------------------------------
module lock_try_counter
    import locker_pkg::*;
#(
    parameter  int MAX_TRIES = 3,
    localparam int CW        = cnt_w(MAX_TRIES)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] count
);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CW'(MAX_TRIES))) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/multi_user_locker.sv
// ---------------------------------------------------------------------------
// multi_user_locker
// N-user digital locker. A correct password opens the lock (Access) for
// UNLOCK_CYCLES cycles; MAX_TRIES consecutive failures by one user raise
// Alarm and block every user for LOCKOUT_CYCLES cycles.
//
// Ports
//   Clk     in  : system clock, rising edge
//   Reset   in  : synchronous, active-high; restores defaults mid-window too
//   User    in  : selected user index, UW bits
//   PassIn  in  : entered password, PASS_W bits
//   Enter   in  : submit strobe (level; rising edge is the submit event)
//   NewPass in  : replacement password (PASS_CHANGE_EN builds only)
//   Change  in  : request password change on submit while open (PASS_CHANGE_EN)
//   Access  out : lock open
//   Count   out : failure count of the selected User (0 if out of range)
//   Alarm   out : lockout active
//
// Build option: define PASS_CHANGE_EN to add per-user password storage and
// the NewPass/Change ports. Without it, passwords are the constant
// DEFAULT_PASS and no storage registers exist.
// ---------------------------------------------------------------------------
module multi_user_locker
    import locker_pkg::*;
#(
    parameter  int                            NUM_USERS      = 4,
    parameter  int                            PASS_W         = 12,
    parameter  int                            MAX_TRIES      = 3,
    parameter  int                            UNLOCK_CYCLES  = 8,
    parameter  int                            LOCKOUT_CYCLES = 16,
    parameter  logic [NUM_USERS*PASS_W-1:0]   DEFAULT_PASS   =
                   {12'h333, 12'h222, 12'hF2A, 12'h111},
    localparam int                            UW = idx_w(NUM_USERS),
    localparam int                            CW = cnt_w(MAX_TRIES),
    localparam int                            TW = tmr_w(UNLOCK_CYCLES, LOCKOUT_CYCLES)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [UW-1:0]     User,
    input  logic [PASS_W-1:0] PassIn,
    input  logic              Enter,
`ifdef PASS_CHANGE_EN
    input  logic [PASS_W-1:0] NewPass,
    input  logic              Change,
`endif
    output logic              Access,
    output logic [CW-1:0]     Count,
    output logic              Alarm
);

    state_t                              state;
    logic   [TW-1:0]                     timer;
    logic   [UW-1:0]                     owner;   // user that opened the lock / tripped the alarm
    logic                                enter_q;
    logic                                submit;
    logic                                user_ok;
    logic                                match;
    logic                                last_try;
    logic                                ok_ev;
    logic                                fail_ev;
    logic                                lock_done;
    logic                                chg_ev;
    logic   [NUM_USERS-1:0][PASS_W-1:0]  pass_cur;
    logic   [NUM_USERS-1:0][CW-1:0]      cnt;
    logic   [NUM_USERS-1:0]              inc;
    logic   [NUM_USERS-1:0]              clr;
    logic   [CW-1:0]                     sel_cnt;

    assign submit = Enter & ~enter_q;

    // With a power-of-2 user count every index is legal; comparing would be
    // a constant-true expression, so only build the compare when needed.
    generate
        if (NUM_USERS == (1 << UW)) begin : g_full_range
            assign user_ok = 1'b1;
        end else begin : g_part_range
            assign user_ok = (User < UW'(NUM_USERS));
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Password source
    // ---------------------------------------------------------------------
`ifdef PASS_CHANGE_EN
    logic [NUM_USERS-1:0][PASS_W-1:0] pass_r;

    assign chg_ev = (state == OPEN) && submit && Change;

    // The write always targets the user that opened the lock, never User.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pass_r <= DEFAULT_PASS;
        end else if (chg_ev) begin
            pass_r[owner] <= NewPass;
        end
    end

    assign pass_cur = pass_r;
`else
    assign chg_ev   = 1'b0;
    assign pass_cur = DEFAULT_PASS;
`endif

    assign match = user_ok && (PassIn == pass_cur[User]);

    // ---------------------------------------------------------------------
    // Per-user failure counters
    // ---------------------------------------------------------------------
    assign sel_cnt  = cnt[User];
    assign Count    = user_ok ? sel_cnt : '0;
    // Counts only advance in IDLE, where none can already be at MAX_TRIES,
    // so "this failure trips the alarm" is simply count == MAX_TRIES-1.
    assign last_try = (sel_cnt >= CW'(MAX_TRIES - 1));

    assign ok_ev     = (state == IDLE) && submit && user_ok &&  match;
    assign fail_ev   = (state == IDLE) && submit && user_ok && !match;
    assign lock_done = (state == LOCKOUT) && (timer == '0);

    always_comb begin
        inc = '0;
        clr = '0;
        for (int u = 0; u < NUM_USERS; u++) begin
            inc[u] = fail_ev && (User == UW'(u));
            clr[u] = (ok_ev && (User == UW'(u))) || (lock_done && (owner == UW'(u)));
        end
    end

    generate
        for (genvar g = 0; g < NUM_USERS; g++) begin : g_cnt
            lock_try_counter #(
                .MAX_TRIES (MAX_TRIES)
            ) u_cnt (
                .Clk   (Clk),
                .Reset (Reset),
                .inc   (inc[g]),
                .clr   (clr[g]),
                .count (cnt[g])
            );
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Control FSM with shared countdown timer; Access/Alarm are registered
    // and each is only set from IDLE, so they can never overlap.
    // ---------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            timer   <= '0;
            owner   <= '0;
            enter_q <= 1'b0;
            Access  <= 1'b0;
            Alarm   <= 1'b0;
        end else begin
            enter_q <= Enter;
            case (state)
                IDLE: begin
                    if (ok_ev) begin
                        Access <= 1'b1;
                        timer  <= TW'(UNLOCK_CYCLES - 1);
                        owner  <= User;
                        state  <= OPEN;
                    end else if (fail_ev && last_try) begin
                        Alarm  <= 1'b1;
                        timer  <= TW'(LOCKOUT_CYCLES - 1);
                        owner  <= User;
                        state  <= LOCKOUT;
                    end
                end
                OPEN: begin
                    if (chg_ev) begin
                        timer <= TW'(UNLOCK_CYCLES - 1);
                    end else if (timer == '0) begin
                        Access <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                LOCKOUT: begin
                    if (timer == '0) begin
                        Alarm <= 1'b0;
                        state <= IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    Access <= 1'b0;
                    Alarm  <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
